// File: rtl/erasable_core_stack_if.sv
// Select/strobe/sense bundle between the memory timing block and the erasable core stack.
// With ERAS_PARITY_EN defined it also carries PARFLIP and PARERR.
interface erasable_core_stack_if #(
   parameter int WIDTH = 16
);
   logic [7:0]       XB;
   logic [7:0]       XT;
   logic [3:0]       YB;
   logic [7:0]       YT;
   logic             REX;
   logic             REY;
   logic             WEX;
   logic             WEY;
   logic             SBE;
   logic [WIDTH-1:0] WDATA;
   logic [WIDTH-1:0] SA;
   logic             SAVALID;
   logic             BUSY;
   logic             HALFSEL;
   logic             SELERR;
`ifdef ERAS_PARITY_EN
   logic             PARFLIP;
   logic             PARERR;
`endif

   modport master (
      output XB, XT, YB, YT, REX, REY, WEX, WEY, SBE, WDATA,
`ifdef ERAS_PARITY_EN
      output PARFLIP,
      input  PARERR,
`endif
      input  SA, SAVALID, BUSY, HALFSEL, SELERR
   );

   modport slave (
      input  XB, XT, YB, YT, REX, REY, WEX, WEY, SBE, WDATA,
`ifdef ERAS_PARITY_EN
      input  PARFLIP,
      output PARERR,
`endif
      output SA, SAVALID, BUSY, HALFSEL, SELERR
   );
endinterface

// File: rtl/erasable_core_stack.sv
// Behavioural coincident-current erasable core (2048 words): destructive read, restore-by-write,
// half-select and select-fault detection. Optional odd-parity storage under ERAS_PARITY_EN.
module erasable_core_stack #(
   parameter int WIDTH        = 16,
   parameter int READ_LATENCY = 2,
   parameter bit CLEAR_ON_RST = 1'b0
) (
   input logic            CLOCK,
   input logic            rst,
   erasable_core_stack_if.slave bus
);
`ifdef ERAS_PARITY_EN
   localparam int CW = WIDTH + 1;
`else
   localparam int CW = WIDTH;
`endif
   localparam int DEPTH = 2048;
   localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, READ, SENSED} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [10:0]      addr_q;
   logic [WIDTH-1:0] sense_q;
   logic [1:0]       cnt_q;
   logic             selerr_q;
`ifdef ERAS_PARITY_EN
   logic             parerr_q;
`endif

   function automatic logic [2:0] enc8(input logic [7:0] v);
      enc8 = '0;
      for (int i = 0; i < 8; i++) if (v[i]) enc8 = 3'(i);
   endfunction

   function automatic logic [1:0] enc4(input logic [3:0] v);
      enc4 = '0;
      for (int i = 0; i < 4; i++) if (v[i]) enc4 = 2'(i);
   endfunction

   logic          sel_ok, full_rd, full_wr, half, active, fault, start_rd, do_wr;
   logic [10:0]   addr_dec;
   logic [CW-1:0] cell_dec, cell_lat, or_word, exact_word;

   assign sel_ok   = $onehot(bus.XB) && $onehot(bus.XT) && $onehot(bus.YB) && $onehot(bus.YT);
   assign addr_dec = {enc8(bus.YT), enc4(bus.YB), enc8(bus.XT), enc8(bus.XB)};
   assign full_rd  = bus.REX & bus.REY;
   assign full_wr  = bus.WEX & bus.WEY;
   assign half     = (bus.REX ^ bus.REY) | (bus.WEX ^ bus.WEY);
   assign active   = (state != READ);
   // Selects are only decoded in IDLE; SENSED works from the latched address.
   assign fault    = active & ((full_rd & (bus.WEX | bus.WEY)) |
                               ((state == IDLE) & (full_rd | full_wr) & ~sel_ok));
   assign start_rd = active & ~fault & ~half & full_rd;
   assign do_wr    = active & ~fault & ~half & full_wr;

   // Without CLEAR_ON_RST the live mask is always honoured as set, so contents survive reset.
   assign cell_dec = (CLEAR_ON_RST && !live_q[addr_dec]) ? '0 : mem[addr_dec];
   assign cell_lat = (CLEAR_ON_RST && !live_q[addr_q])   ? '0 : mem[addr_q];

`ifdef ERAS_PARITY_EN
   logic [WIDTH-1:0] or_data;
   assign or_data    = cell_dec[WIDTH-1:0] | bus.WDATA;
   assign or_word    = {~(^or_data) ^ bus.PARFLIP, or_data};
   assign exact_word = {~(^bus.WDATA) ^ bus.PARFLIP, bus.WDATA};
`else
   assign or_word    = cell_dec | bus.WDATA;
   assign exact_word = bus.WDATA;
`endif

   always_ff @(posedge CLOCK) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_rd) state_next = READ;
         READ:    if (cnt_q == 2'd0) state_next = SENSED;
         SENSED:  if (start_rd) state_next = READ;
                  else if (do_wr) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.BUSY    = (state == READ);
      bus.SAVALID = (state == SENSED) && bus.SBE;
      bus.SA      = bus.SAVALID ? sense_q : '0;
      bus.HALFSEL = active & ~fault & half & ~rst;
      bus.SELERR  = selerr_q;
`ifdef ERAS_PARITY_EN
      bus.PARERR  = parerr_q;
`endif
   end

   // Array, latched address, latency counter and sense register.
   always_ff @(posedge CLOCK) begin
      if (rst) begin
         addr_q   <= '0;
         sense_q  <= '0;
         cnt_q    <= '0;
         selerr_q <= 1'b0;
         if (CLEAR_ON_RST) live_q <= '0;
`ifdef ERAS_PARITY_EN
         parerr_q <= 1'b0;
`endif
      end else begin
         if (fault) selerr_q <= 1'b1;
         case (state)
            IDLE: begin
               if (start_rd) begin
                  addr_q <= addr_dec;
                  cnt_q  <= LAT_M1;
               end else if (do_wr) begin
                  mem[addr_dec]    <= or_word;
                  live_q[addr_dec] <= 1'b1;
               end
            end
            READ: begin
               if (cnt_q == 2'd0) begin
                  sense_q        <= cell_lat[WIDTH-1:0];
                  mem[addr_q]    <= '0;
                  live_q[addr_q] <= 1'b1;
`ifdef ERAS_PARITY_EN
                  parerr_q       <= ~(^cell_lat);
`endif
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            SENSED: begin
               if (start_rd) begin
                  cnt_q <= LAT_M1;
               end else if (do_wr) begin
                  mem[addr_q]    <= exact_word;
                  live_q[addr_q] <= 1'b1;
                  sense_q        <= '0;
`ifdef ERAS_PARITY_EN
                  parerr_q       <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_erasable_core_stack.sv
// Randomized self-checking bench for erasable_core_stack against a word-array reference model.
// Parity checks compile in only with ERAS_PARITY_EN defined.
module tb_erasable_core_stack;
   localparam int WIDTH = 16;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [WIDTH-1:0] model_mem [2048];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   erasable_core_stack_if #(.WIDTH(WIDTH)) bus ();

   erasable_core_stack #(.WIDTH(WIDTH), .READ_LATENCY(2), .CLEAR_ON_RST(1'b0)) dut (
      .CLOCK (clk),
      .rst   (rst),
      .bus   (bus)
   );

   task automatic set_sel(input logic [10:0] a);
      bus.XB = 8'b1 << a[2:0];
      bus.XT = 8'b1 << a[5:3];
      bus.YB = 4'b1 << a[7:6];
      bus.YT = 8'b1 << a[10:8];
   endtask

   // Full read strobe for one cycle, then count BUSY cycles (bounded); ends in SENSED at a negedge.
   task automatic start_read(input logic [10:0] a, output int busy_cycles);
      @(negedge clk);
      set_sel(a);
      bus.REX = 1'b1; bus.REY = 1'b1;
      @(negedge clk);
      bus.REX = 1'b0; bus.REY = 1'b0;
      busy_cycles = 0;
      while (bus.BUSY === 1'b1 && busy_cycles < 20) begin
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic sense(output logic [WIDTH-1:0] data, output logic valid);
      bus.SBE = 1'b1;
      #1;
      data  = bus.SA;
      valid = bus.SAVALID;
      bus.SBE = 1'b0;
   endtask

   task automatic write_idle(input logic [10:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      set_sel(a);
      bus.WDATA = d;
      bus.WEX = 1'b1; bus.WEY = 1'b1;
      @(negedge clk);
      bus.WEX = 1'b0; bus.WEY = 1'b0;
      model_mem[a] = model_mem[a] | d;
   endtask

   // Restore write in SENSED; selects are deliberately garbage since they must not be decoded.
   task automatic write_sensed(input logic [10:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      bus.XB = 8'h03;
      bus.WDATA = d;
      bus.WEX = 1'b1; bus.WEY = 1'b1;
      @(negedge clk);
      bus.WEX = 1'b0; bus.WEY = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic prime(input logic [10:0] a, input logic [WIDTH-1:0] d);
      int b;
      start_read(a, b);
      checks++;
      if (b !== 2) begin errors++; $display("[TB] FAIL prime_busy: got %0d cycles, expected 2", b); end
      write_sensed(a, d);
   endtask

   task automatic read_check(input string name, input logic [10:0] a);
      int b;
      logic [WIDTH-1:0] d;
      logic v;
      start_read(a, b);
      checks++;
      if (b !== 2) begin errors++; $display("[TB] FAIL %s_busy: got %0d cycles, expected 2", name, b); end
      sense(d, v);
      checks++;
      if (d !== model_mem[a] || v !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_sa: got %h/%b, expected %h/1", name, d, v, model_mem[a]);
      end
      model_mem[a] = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.SA, bus.SAVALID, bus.BUSY, bus.HALFSEL, bus.SELERR} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got SA=%h V=%b B=%b H=%b E=%b, expected all 0",
                  bus.SA, bus.SAVALID, bus.BUSY, bus.HALFSEL, bus.SELERR);
      end
   endtask

   task automatic test_write_read();
      prime(11'h4D1, '0);
      write_idle(11'h4D1, 16'h5A3C);
      read_check("wr_rd", 11'h4D1);
      #1;
      checks++;
      if (bus.SA !== '0 || bus.SAVALID !== 1'b0) begin
         errors++; $display("[TB] FAIL sbe_gate: got %h/%b, expected 0/0", bus.SA, bus.SAVALID);
      end
   endtask

   task automatic test_back_to_back();
      read_check("reread_zero", 11'h4D1);
      write_sensed(11'h4D1, 16'h1111);
      read_check("restore", 11'h4D1);
      write_sensed(11'h4D1, 16'h1111);
   endtask

   task automatic test_or_write();
      prime(11'h000, '0);
      write_idle(11'h000, 16'h00F0);
      write_idle(11'h000, 16'h0F00);
      read_check("or_write", 11'h000);
      write_sensed(11'h000, 16'h0FF0);
   endtask

   task automatic test_half_select();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_sel(11'h4D1);
         bus.REX = 1'b1;
         #1;
         checks++;
         if (bus.HALFSEL !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++; $display("[TB] FAIL halfsel_rex: got H=%b B=%b, expected 1/0", bus.HALFSEL, bus.BUSY);
         end
      end
      @(negedge clk);
      bus.REX = 1'b0;
      bus.WDATA = 16'hFFFF;
      bus.WEX = 1'b1;
      #1;
      checks++;
      if (bus.HALFSEL !== 1'b1) begin
         errors++; $display("[TB] FAIL halfsel_wex: got %b, expected 1", bus.HALFSEL);
      end
      @(negedge clk);
      bus.WEX = 1'b0;
      #1;
      checks++;
      if (bus.HALFSEL !== 1'b0 || bus.SELERR !== 1'b0) begin
         errors++; $display("[TB] FAIL halfsel_after: got H=%b E=%b, expected 0/0", bus.HALFSEL, bus.SELERR);
      end
      read_check("halfsel_mem", 11'h4D1);
      write_sensed(11'h4D1, 16'h1111);
   endtask

   task automatic test_select_fault();
      @(negedge clk);
      set_sel(11'h123);
      bus.XB = 8'h03;
      bus.REX = 1'b1; bus.REY = 1'b1;
      @(negedge clk);
      bus.REX = 1'b0; bus.REY = 1'b0;
      checks++;
      if (bus.SELERR !== 1'b1 || bus.BUSY !== 1'b0) begin
         errors++; $display("[TB] FAIL selfault_set: got E=%b B=%b, expected 1/0", bus.SELERR, bus.BUSY);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.SELERR !== 1'b1) begin
         errors++; $display("[TB] FAIL selfault_sticky: got %b, expected 1", bus.SELERR);
      end
      @(negedge clk);
      set_sel(11'h4D1);
      bus.WDATA = 16'hFFFF;
      {bus.REX, bus.REY, bus.WEX, bus.WEY} = 4'b1111;
      @(negedge clk);
      {bus.REX, bus.REY, bus.WEX, bus.WEY} = 4'b0000;
      read_check("rmw_fault_mem", 11'h4D1);
      write_sensed(11'h4D1, 16'h1111);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.SELERR !== 1'b0) begin
         errors++; $display("[TB] FAIL selfault_clear: got %b, expected 0", bus.SELERR);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [WIDTH-1:0] d;
      logic v;
      prime(11'h2A5, 16'hBEEF);
      @(negedge clk);
      set_sel(11'h2A5);
      bus.REX = 1'b1; bus.REY = 1'b1;
      @(negedge clk);
      bus.REX = 1'b0; bus.REY = 1'b0;
      checks++;
      if (bus.BUSY !== 1'b1) begin
         errors++; $display("[TB] FAIL midread_busy: got %b, expected 1", bus.BUSY);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sense(d, v);
      checks++;
      if ({d, v, bus.BUSY, bus.HALFSEL, bus.SELERR} !== '0) begin
         errors++;
         $display("[TB] FAIL midread_outputs: got SA=%h V=%b B=%b H=%b E=%b, expected all 0",
                  d, v, bus.BUSY, bus.HALFSEL, bus.SELERR);
      end
      read_check("midread_survive", 11'h2A5);
      write_sensed(11'h2A5, 16'hBEEF);
   endtask

   task automatic test_random();
      logic [10:0] pool [8];
      for (int i = 0; i < 8; i++) begin
         pool[i] = 11'($urandom);
         prime(pool[i], 16'($urandom));
      end
      for (int n = 0; n < 30; n++) begin
         logic [10:0] a;
         a = pool[$urandom_range(0, 7)];
         case ($urandom_range(0, 2))
            0: write_idle(a, 16'($urandom) & 16'($urandom));
            1: begin
               read_check("rand_read", a);
               write_sensed(a, 16'($urandom));
            end
            default: begin
               read_check("rand_read", a);
               read_check("rand_reread", a);
               write_sensed(a, 16'($urandom));
            end
         endcase
      end
   endtask

`ifdef ERAS_PARITY_EN
   task automatic test_parity();
      logic expect_err;
      for (int k = 0; k < 2; k++) begin
         expect_err = (k == 0);
         prime(11'h010, '0);
         @(negedge clk);
         set_sel(11'h010);
         bus.WDATA = 16'h0001;
         bus.PARFLIP = expect_err;
         bus.WEX = 1'b1; bus.WEY = 1'b1;
         @(negedge clk);
         bus.WEX = 1'b0; bus.WEY = 1'b0;
         bus.PARFLIP = 1'b0;
         model_mem[11'h010] = 16'h0001;
         read_check("parity_data", 11'h010);
         checks++;
         if (bus.PARERR !== expect_err) begin
            errors++; $display("[TB] FAIL parerr: got %b, expected %b", bus.PARERR, expect_err);
         end
         write_sensed(11'h010, '0);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.XB = '0; bus.XT = '0; bus.YB = '0; bus.YT = '0;
      bus.REX = 1'b0; bus.REY = 1'b0; bus.WEX = 1'b0; bus.WEY = 1'b0;
      bus.SBE = 1'b0; bus.WDATA = '0;
`ifdef ERAS_PARITY_EN
      bus.PARFLIP = 1'b0;
`endif
      test_reset();
      test_write_read();
      test_back_to_back();
      test_or_write();
      test_half_select();
      test_select_fault();
      test_reset_mid_read();
      test_random();
`ifdef ERAS_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
